// File: rtl/window_generator_7x7.sv
// Streaming 7x7 window generator: six line buffers feed a 7x7 shift-register
// window; each accepted pixel yields one window tagged with its centre pixel.
module window_generator_7x7 #(
  parameter int BW        = 8,
  parameter int IM_WIDTH  = 640,
  parameter int IM_HEIGHT = 480,
  parameter int XW        = $clog2(IM_WIDTH),
  parameter int YW        = $clog2(IM_HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BW-1:0]            px_in,
  input  logic                     px_valid,
  input  logic                     frame_start,
  output logic [6:0][6:0][BW-1:0]  px_window,
  output logic                     window_valid,
  output logic [XW-1:0]            center_x,
  output logic [YW-1:0]            center_y
);

  logic [XW-1:0] x, cur_x, cen_x;
  logic [YW-1:0] y, cur_y, cen_y;
  logic [BW-1:0] line_buf [6][IM_WIDTH];
  logic [6:0][BW-1:0] col_vec;

  // Coordinates of the current pixel; frame_start forces (0,0)
  always_comb begin
    cur_x = frame_start ? '0 : x;
    cur_y = frame_start ? '0 : y;
    cen_x = (cur_x >= XW'(3)) ? cur_x - XW'(3) : cur_x + XW'(IM_WIDTH - 3);
    cen_y = (cur_y >= YW'(3)) ? cur_y - YW'(3) : cur_y + YW'(IM_HEIGHT - 3);
  end

  // Column vector: newest line at row 6, oldest buffered line at row 0
  always_comb begin
    col_vec    = '0;
    col_vec[6] = px_in;
    for (int unsigned k = 0; k < 6; k++) begin
      col_vec[5 - k] = line_buf[k][cur_x];
    end
  end

  // Raster counters with line and frame wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (px_valid) begin
      if (cur_x == XW'(IM_WIDTH - 1)) begin
        x <= '0;
        y <= (cur_y == YW'(IM_HEIGHT - 1)) ? '0 : cur_y + 1'b1;
      end else begin
        x <= cur_x + 1'b1;
        y <= cur_y;
      end
    end
  end

  // Line buffers: cascade each column one line down, read before write
  always_ff @(posedge clk) begin
    if (px_valid) begin
      line_buf[0][cur_x] <= px_in;
      for (int unsigned k = 1; k < 6; k++) begin
        line_buf[k][cur_x] <= line_buf[k - 1][cur_x];
      end
    end
  end

  // Window shift, centre coordinates and validity flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px_window    <= '0;
      window_valid <= 1'b0;
      center_x     <= '0;
      center_y     <= '0;
    end else if (px_valid) begin
      for (int unsigned r = 0; r < 7; r++) begin
        for (int unsigned c = 0; c < 6; c++) begin
          px_window[r][c] <= px_window[r][c + 1];
        end
        px_window[r][6] <= col_vec[r];
      end
      center_x     <= cen_x;
      center_y     <= cen_y;
      window_valid <= (cur_x >= XW'(6)) && (cur_y >= YW'(6));
    end else begin
      window_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_generator_7x7.sv
// Directed bench for window_generator_7x7 on a 16x8 image.
module tb_window_generator_7x7;

  localparam int BW = 8;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int WB = 49 * BW;

  logic                    clk;
  logic                    rst_n;
  logic [BW-1:0]           px_in;
  logic                    px_valid;
  logic                    frame_start;
  logic [6:0][6:0][BW-1:0] px_window;
  logic                    window_valid;
  logic [XW-1:0]           center_x;
  logic [YW-1:0]           center_y;

  window_generator_7x7 #(
    .BW(BW),
    .IM_WIDTH(W),
    .IM_HEIGHT(H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .px_in(px_in),
    .px_valid(px_valid),
    .frame_start(frame_start),
    .px_window(px_window),
    .window_valid(window_valid),
    .center_x(center_x),
    .center_y(center_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int last_cx = 0;
  int last_cy = 0;
  bit hold_known = 0;
  logic [WB-1:0] hold_win;
  int hold_cx;
  int hold_cy;

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] pix(input int x, input int y, input int ofs);
    return BW'((16 * y + x + ofs) & 255);
  endfunction

  // Expected window after pixel (x,y): element [r][c] = pixel (x-6+c, y-6+r)
  function automatic logic [WB-1:0] model_win(input int x, input int y, input int ofs);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        w[(r * 7 + c) * BW +: BW] = pix(x - 6 + c, y - 6 + r, ofs);
    return w;
  endfunction

  task automatic send(input int x, input int y, input int ofs, input bit fs);
    logic [WB-1:0] mw;
    px_in       = pix(x, y, ofs);
    px_valid    = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    px_valid    = 1'b0;
    frame_start = 1'b0;
    if (x >= 6 && y >= 6) begin
      pulses++;
      mw = model_win(x, y, ofs);
      check("valid", WB'(window_valid), WB'(1));
      check("center_x", WB'(center_x), WB'(x - 3));
      check("center_y", WB'(center_y), WB'(y - 3));
      check("window", px_window, mw);
      hold_known = 1;
      hold_win   = mw;
      hold_cx    = x - 3;
      hold_cy    = y - 3;
      last_cx    = int'(center_x);
      last_cy    = int'(center_y);
    end else begin
      check("no_valid", WB'(window_valid), WB'(0));
      hold_known = 0;
    end
  endtask

  task automatic idle();
    px_valid    = 1'b0;
    frame_start = 1'($urandom_range(1));
    px_in       = BW'($urandom);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    check("idle_valid", WB'(window_valid), WB'(0));
    if (hold_known) begin
      check("idle_window", px_window, hold_win);
      check("idle_cx", WB'(center_x), WB'(hold_cx));
      check("idle_cy", WB'(center_y), WB'(hold_cy));
    end
  endtask

  task automatic send_frame(input int ofs, input bit bubbles, input bit fs, input int count);
    int x, y;
    for (int i = 0; i < count; i++) begin
      x = i % W;
      y = i / W;
      if (bubbles) repeat ($urandom_range(0, 2)) idle();
      send(x, y, ofs, fs && (i == 0));
      if (x == 6 && y == 6 && ofs == 0) begin
        check("first_33", WB'(px_window[3][3]), WB'(51));
        check("first_00", WB'(px_window[0][0]), WB'(0));
        check("first_66", WB'(px_window[6][6]), WB'(102));
        check("first_06", WB'(px_window[0][6]), WB'(6));
        check("first_60", WB'(px_window[6][0]), WB'(96));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, WB'(window_valid), WB'(0));
    check({tag, "_window"}, px_window, WB'(0));
    check({tag, "_cx"}, WB'(center_x), WB'(0));
    check({tag, "_cy"}, WB'(center_y), WB'(0));
    hold_known = 1;
    hold_win   = '0;
    hold_cx    = 0;
    hold_cy    = 0;
  endtask

  initial begin
    rst_n       = 1'b0;
    px_in       = '0;
    px_valid    = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) idle();

    // Full frame, continuous input
    pulses = 0;
    send_frame(0, 0, 1, W * H);
    check("frame_pulses", WB'(pulses), WB'(20));
    check("last_cx", WB'(last_cx), WB'(12));
    check("last_cy", WB'(last_cy), WB'(4));

    // Same frame with random bubbles
    pulses = 0;
    send_frame(0, 1, 1, W * H);
    check("bubble_pulses", WB'(pulses), WB'(20));

    // Two frames back to back, second without frame_start
    pulses = 0;
    send_frame(0, 0, 1, W * H);
    send_frame(128, 0, 0, W * H);
    check("wrap_pulses", WB'(pulses), WB'(40));

    // frame_start arriving at what would be pixel (9,7)
    send_frame(0, 0, 1, 7 * W + 9);
    pulses = 0;
    send_frame(0, 0, 1, W * H);
    check("restart_pulses", WB'(pulses), WB'(20));

    // Reset at pixel (10,7), then resume from (0,0) without frame_start
    send_frame(0, 0, 1, 7 * W + 10);
    rst_n    = 1'b0;
    px_in    = pix(10, 7, 0);
    px_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    px_valid = 1'b0;
    check_zero("midreset");
    pulses = 0;
    send_frame(0, 0, 0, W * H);
    check("reset_pulses", WB'(pulses), WB'(20));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_generator_7x7.md
Name: window_generator_7x7

Overview:
- Streaming 7x7 window generator. Upstream is a raster pixel stream; the output feeds fast_detector-style consumers that take a 7x7 px_window.
- Buffers 6 full image lines and keeps a 7x7 shift-register window.
- Each accepted pixel produces one window, tagged with the coordinates of its centre pixel.
- A valid flag marks windows that lie entirely inside the image.

Parameters:
- BW, 8, pixel bit width.
- IM_WIDTH, 640, pixels per line (>= 7).
- IM_HEIGHT, 480, lines per frame (>= 7).
- XW, $clog2(IM_WIDTH), width of x coordinate (derived).
- YW, $clog2(IM_HEIGHT), width of y coordinate (derived).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- px_in  in  BW  input pixel, raster order.
- px_valid  in  1  px_in is accepted on this cycle.
- frame_start  in  1  qualifies px_in as pixel (0,0) of a new frame; ignored unless px_valid=1.
- px_window  out  [6:0][6:0][BW-1:0]  window, indexed [row][col]; row 0 = oldest line (top), col 0 = leftmost.
- window_valid  out  1  one-cycle pulse: px_window is a complete in-image window.
- center_x  out  XW  x coordinate of px_window[3][3].
- center_y  out  YW  y coordinate of px_window[3][3].

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at posedge):
  - px_window = all zero; window_valid = 0; center_x = 0; center_y = 0.
  - Input counters x = 0, y = 0.
  - Line-buffer RAM contents are not reset; stale contents are masked by the window_valid gating below.
- Input coordinates:
  - (x,y) is the coordinate of the current px_in.
  - On an accepted pixel: x increments; at x = IM_WIDTH-1, x wraps to 0 and y increments.
  - At (IM_WIDTH-1, IM_HEIGHT-1), both wrap to (0,0), so the next frame starts without needing frame_start.
  - px_valid & frame_start: the pixel is treated as (0,0) and the counters continue from (1,0). This overrides any counter state, including mid-frame.
- Line buffers:
  - 6 buffers, each IM_WIDTH x BW, addressed by x. Buffer k holds line y-1-k.
  - On an accepted pixel, read all 6 at address x, then write px_in into buffer 0 and buffer k-1 into buffer k (read-before-write).
  - Column vector for the accepted pixel: row 6 = px_in, row 5 = buf0[x], ..., row 0 = buf5[x].
- Window:
  - On an accepted pixel, every row shifts left one column (col c <= col c+1) and the new column vector loads into col 6.
  - When px_valid=0, px_window, center_x and center_y hold.
- Latency: exactly 1 cycle. At the edge after pixel (x,y) is accepted:
  - px_window[6][6] = pixel (x,y) and px_window[r][c] = pixel (x-6+c, y-6+r).
  - center_x = x-3 and center_y = y-3, computed modulo width; meaningful only when window_valid=1.
  - window_valid = (x >= 6) && (y >= 6).
- Valid-window count: windows whose columns would span a line boundary (x < 6), or that include lines from a previous frame or from reset (y < 6), are never flagged. Each frame gives exactly (IM_WIDTH-6)*(IM_HEIGHT-6) pulses.
- Idle cycles: window_valid = 0 on any cycle following a cycle with px_valid=0. Bubbles never change which windows are produced or their contents.
- Pixels are never dropped; there is no backpressure. A consumer must accept a window on every pulse.
- Mid-frame frame_start: the new frame's first 6 lines produce no valid windows, so stale data is never flagged.
- Mid-operation reset: the next accepted pixel is (0,0); no window is valid until (6,6).

Test Plan:
- Setup for all tests: IM_WIDTH=16, IM_HEIGHT=8, pixel value = (16*y+x) mod 256, frame_start on (0,0), continuous px_valid.
- First window: one cycle after pixel (6,6), expect window_valid=1, center=(3,3), [3][3]=51, [0][0]=0, [6][6]=102, [0][6]=6, [6][0]=96.
- Full frame:
  - Exactly 20 valid pulses.
  - Every pulse has [3][3] = 16*center_y+center_x.
  - The last pulse has center=(12,4) after pixel (15,7).
  - No pulse for any pixel with x<6 or y<6.
- Bubbles: drive the same frame with px_valid randomly deasserted ~50% of the time. Expect the identical sequence of 20 (center, window) pairs, window_valid never high after an idle cycle, and outputs held during idle.
- Frame wrap: send two frames back-to-back without a second frame_start. Expect 40 pulses total; second-frame windows contain only second-frame values (offset by +128 for the second frame's data).
- Mid-frame frame_start at pixel (9,7): the counters restart. Expect no pulses until the new (6,6), and a first pulse with center=(3,3) and correct new-frame data.
- Reset: assert rst_n=0 for 1 cycle at (10,7). Expect all outputs zero the next cycle; resume feeding from (0,0) and expect the first pulse only after (6,6), with 20 pulses in that frame.
